alu_div_seq: RTL and testbench

- Multi-cycle unsigned restoring divider. Produces the resultDIV operand for the ALU result multiplexer (ALUControl 4'b0011).
- Operands are captured on a start pulse. One quotient bit is resolved per clock.
- Completion is flagged by a one-cycle done pulse. Quotient and remainder then hold stable until the next accepted start.
- The control path stalls on busy while the divide runs.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/div_step.sv | 29 ++
 rtl/alu_div_seq.sv | 119 +++++++++++
 tb/tb_alu_div_seq.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: result-mux control encodings, divider FSM states
// and the iteration-counter width helper.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_MUL = 4'b0010;
    localparam logic [3:0] ALU_DIV = 4'b0011;
    localparam logic [3:0] ALU_AND = 4'b0100;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_NOT = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } div_state_t;

    // Counter must hold the value N itself, hence N+1 codes.
    function automatic int div_cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract D,
// restore on a negative result and shift the quotient bit into Q.
module div_step #(
    parameter int N = 4
) (
    input  logic [N:0]   r_i,
    input  logic [N-1:0] q_i,
    input  logic [N-1:0] d_i,
    output logic [N:0]   r_o,
    output logic [N-1:0] q_o
);

    logic [N+1:0] shift_s;
    logic [N+1:0] diff_s;

    // Top bit of diff_s is the borrow: set means the trial subtract went negative.
    always_comb begin
        shift_s = {r_i, q_i[N-1]};
        diff_s  = shift_s - {2'b00, d_i};
        if (diff_s[N+1] == 1'b0) begin
            r_o = diff_s[N:0];
            q_o = {q_i[N-2:0], 1'b1};
        end else begin
            r_o = shift_s[N:0];
            q_o = {q_i[N-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/alu_div_seq.sv
// Multi-cycle unsigned restoring divider feeding the ALU resultDIV operand;
// one quotient bit per clock, results held until the next accepted start.
module alu_div_seq
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         divByZero
);

    localparam int CW = div_cnt_w(N);

    div_state_t   state_q, state_d;
    logic [N:0]   r_q, r_d, step_r_s;
    logic [N-1:0] q_q, q_d, step_q_s;
    logic [N-1:0] d_q, d_d;
    logic [N-1:0] quot_q, quot_d;
    logic [N-1:0] rem_q, rem_d;
    logic         dbz_q, dbz_d;
    logic [CW-1:0] cnt_q, cnt_d;

    div_step #(.N(N)) u_step (
        .r_i (r_q),
        .q_i (q_q),
        .d_i (d_q),
        .r_o (step_r_s),
        .q_o (step_q_s)
    );

    // State and datapath registers; reset aborts any divide in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; result registers only move on the DONE-entry edge.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        q_d     = dividend;
                        d_d     = divisor;
                        r_d     = '0;
                        cnt_d   = CW'(N);
                        state_d = RUN;
                    end else begin
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                r_d   = step_r_s;
                q_d   = step_q_s;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    quot_d  = step_q_s;
                    rem_d   = step_r_s[N-1:0];
                    dbz_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign divByZero = dbz_q;

endmodule

// File: tb/tb_alu_div_seq.sv
// Directed + random bench for alu_div_seq at N=4 and N=8 with a scoreboard queue.
module tb_alu_div_seq;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start4, start8;
    logic [3:0] dvd4, dvs4, q4, r4;
    logic [7:0] dvd8, dvs8, q8, r8;
    logic       busy4, done4, dbz4, busy8, done8, dbz8;

    alu_div_seq #(.N(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .dividend(dvd4), .divisor(dvs4),
        .busy(busy4), .done(done4), .quotient(q4), .remainder(r4), .divByZero(dbz4)
    );

    alu_div_seq #(.N(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .dividend(dvd8), .divisor(dvs8),
        .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .divByZero(dbz8)
    );

    function automatic logic get_done(input bit w8);
        return w8 ? done8 : done4;
    endfunction

    function automatic logic get_busy(input bit w8);
        return w8 ? busy8 : busy4;
    endfunction

    function automatic logic [31:0] get_q(input bit w8);
        return w8 ? {24'd0, q8} : {28'd0, q4};
    endfunction

    function automatic logic [31:0] get_r(input bit w8);
        return w8 ? {24'd0, r8} : {28'd0, r4};
    endfunction

    function automatic logic get_dbz(input bit w8);
        return w8 ? dbz8 : dbz4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Drive a one-cycle start pulse and push the reference result.
    task automatic issue(input bit w8, input logic [7:0] a, input logic [7:0] b, input string tag);
        exp_t e;
        @(negedge clk);
        if (w8) begin
            start8 = 1'b1; dvd8 = a; dvs8 = b;
        end else begin
            start4 = 1'b1; dvd4 = a[3:0]; dvs4 = b[3:0];
        end
        e.a   = a;
        e.b   = b;
        e.dbz = (b == 8'd0);
        if (b == 8'd0) begin
            e.q = w8 ? 8'hFF : 8'h0F;
            e.r = a;
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        sb.push_back(e);
        @(negedge clk);
        start4 = 1'b0;
        start8 = 1'b0;
        chk({tag, "_busy"}, {31'd0, get_busy(w8)}, 32'd1);
    endtask

    // Wait (bounded) for done, pop the scoreboard and compare; optionally
    // pulse start again during the DONE cycle, which must be ignored.
    task automatic wait_done(input bit w8, input string tag, input int exp_edges,
                             input int edges0, input bit poke);
        int   edges;
        exp_t e;
        edges = edges0;
        while (!get_done(w8) && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        if (poke) begin
            start4 = 1'b1; dvd4 = 4'd6; dvs4 = 4'd2;
        end
        chk({tag, "_lat"}, edges, exp_edges);
        chk({tag, "_sbsz"}, sb.size(), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_q"}, get_q(w8), {24'd0, e.q});
            chk({tag, "_r"}, get_r(w8), {24'd0, e.r});
            chk({tag, "_dbz"}, {31'd0, get_dbz(w8)}, {31'd0, e.dbz});
            if (e.b != 8'd0) begin
                chk({tag, "_inv"}, get_q(w8) * e.b + get_r(w8), {24'd0, e.a});
                chk({tag, "_rlt"}, {31'd0, get_r(w8) < e.b}, 32'd1);
            end
        end
        @(negedge clk);
        start4 = 1'b0;
        chk({tag, "_pulse"}, {31'd0, get_done(w8)}, 32'd0);
        chk({tag, "_idle"}, {31'd0, get_busy(w8)}, 32'd0);
    endtask

    initial begin
        int         extra;
        logic [7:0] a, b;

        reset  = 1'b1;
        start4 = 1'b0; start8 = 1'b0;
        dvd4 = 4'd0; dvs4 = 4'd0; dvd8 = 8'd0; dvs8 = 8'd0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy4", {31'd0, busy4}, 32'd0);
        chk("rst_done4", {31'd0, done4}, 32'd0);
        chk("rst_q4", {28'd0, q4}, 32'd0);
        chk("rst_r4", {28'd0, r4}, 32'd0);
        chk("rst_dbz4", {31'd0, dbz4}, 32'd0);
        chk("rst_busy8", {31'd0, busy8}, 32'd0);
        chk("rst_q8", {24'd0, q8}, 32'd0);
        reset = 1'b0;

        // 13/3 with latency and hold check
        issue(1'b0, 8'd13, 8'd3, "d13_3");
        wait_done(1'b0, "d13_3", 5, 1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_q", {28'd0, q4}, 32'd4);
            chk("hold_r", {28'd0, r4}, 32'd1);
            chk("hold_done", {31'd0, done4}, 32'd0);
        end

        // boundaries
        issue(1'b0, 8'd15, 8'd1, "d15_1");  wait_done(1'b0, "d15_1", 5, 1, 1'b0);
        issue(1'b0, 8'd2, 8'd7, "d2_7");    wait_done(1'b0, "d2_7", 5, 1, 1'b0);
        issue(1'b0, 8'd0, 8'd5, "d0_5");    wait_done(1'b0, "d0_5", 5, 1, 1'b0);
        issue(1'b0, 8'd15, 8'd15, "d15_15"); wait_done(1'b0, "d15_15", 5, 1, 1'b0);
        issue(1'b0, 8'd15, 8'd8, "d15_8");  wait_done(1'b0, "d15_8", 5, 1, 1'b0);

        // divide by zero then a normal divide clears the flag
        issue(1'b0, 8'd5, 8'd0, "dz5_0");   wait_done(1'b0, "dz5_0", 1, 1, 1'b0);
        issue(1'b0, 8'd9, 8'd2, "d9_2");    wait_done(1'b0, "d9_2", 5, 1, 1'b0);

        // start while busy (during RUN and during DONE) is ignored
        issue(1'b0, 8'd13, 8'd3, "busy");
        @(negedge clk);
        start4 = 1'b1; dvd4 = 4'd6; dvs4 = 4'd2;
        @(negedge clk);
        start4 = 1'b0;
        wait_done(1'b0, "busy", 5, 3, 1'b1);
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done4) extra++;
        end
        chk("busy_extra_done", extra, 32'd0);
        chk("busy_hold_q", {28'd0, q4}, 32'd4);
        chk("busy_hold_r", {28'd0, r4}, 32'd1);

        // asynchronous reset mid-divide
        @(negedge clk);
        start4 = 1'b1; dvd4 = 4'd14; dvs4 = 4'd3;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_q", {28'd0, q4}, 32'd0);
        chk("mid_rst_r", {28'd0, r4}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy4}, 32'd0);
        chk("mid_rst_done", {31'd0, done4}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done4) extra++;
        end
        chk("mid_rst_no_done", extra, 32'd0);
        issue(1'b0, 8'd14, 8'd3, "d14_3");  wait_done(1'b0, "d14_3", 5, 1, 1'b0);

        // N=8
        issue(1'b1, 8'd200, 8'd7, "w200_7"); wait_done(1'b1, "w200_7", 9, 1, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom_range(0, 255));
            b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            issue(1'b1, a, b, "rnd");
            wait_done(1'b1, "rnd", (b == 8'd0) ? 1 : 9, 1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
